// File: rtl/tff_counter.sv
// ---------------------------------------------------------------------------
// tff_counter
//   WIDTH-bit bank of toggle flip-flops. It can toggle individual bits, count
//   up, count down, or take a parallel load. The up and down counts are built
//   as a toggle carry chain: bit i toggles when every lower bit is 1 (up) or
//   when every lower bit is 0 (down). An optional saturation mode stops the
//   count at the limit instead of letting it wrap. A registered flag marks
//   each clock edge at which the count reached its limit.
//
// Parameters
//   WIDTH     number of toggle flops (>= 1)
//   RST_VAL   value of q while reset is asserted
//   SATURATE  0 = wrap at the limit, 1 = hold at the limit
//
// Ports
//   i_clk       rising-edge clock
//   i_rst_n     asynchronous active-low reset
//   i_en        update enable (a load is still honoured when i_en is 0)
//   i_mode      00 hold, 01 per-bit toggle, 10 count up, 11 count down
//   i_t         per-bit toggle request, used only in mode 01
//   i_load      synchronous parallel load; highest priority after reset
//   i_load_val  value written on a load
//   o_q         register state
//   o_q_bar     bitwise inverse of o_q
//   o_wrap      one-cycle pulse: the previous edge hit the count limit
// ---------------------------------------------------------------------------
module tff_counter #(
  parameter int unsigned          WIDTH    = 4,
  parameter logic [WIDTH-1:0]     RST_VAL  = '0,
  parameter bit                   SATURATE = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_t,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_q_bar,
  output logic             o_wrap
);

  localparam logic [1:0] MODE_HOLD   = 2'b00;
  localparam logic [1:0] MODE_TOGGLE = 2'b01;
  localparam logic [1:0] MODE_UP     = 2'b10;
  localparam logic [1:0] MODE_DOWN   = 2'b11;

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;

  logic [WIDTH-1:0] w_up_tgl;
  logic [WIDTH-1:0] w_dn_tgl;
  logic             w_at_max;
  logic             w_at_min;
  logic [WIDTH-1:0] w_q_next;
  logic             w_wrap_next;

  // Toggle-enable carry chains. Bit 0 always toggles in a count mode, and
  // each higher bit toggles only when every bit below it is at the rollover
  // value. Chain width equals WIDTH, so no carry leaves the bank.
  assign w_up_tgl[0] = 1'b1;
  assign w_dn_tgl[0] = 1'b1;

  for (genvar gi = 1; gi < WIDTH; gi++) begin : g_chain
    assign w_up_tgl[gi] = w_up_tgl[gi-1] &  r_q[gi-1];
    assign w_dn_tgl[gi] = w_dn_tgl[gi-1] & ~r_q[gi-1];
  end

  assign w_at_max = &r_q;
  assign w_at_min = ~|r_q;

  always_comb begin
    w_q_next    = r_q;
    w_wrap_next = 1'b0;
    if (i_load) begin
      w_q_next = i_load_val;
    end else if (i_en) begin
      case (i_mode)
        MODE_HOLD: begin
          w_q_next = r_q;
        end
        MODE_TOGGLE: begin
          w_q_next = r_q ^ i_t;
        end
        MODE_UP: begin
          // At all-ones the chain alone rolls over to zero. Saturation
          // overrides this by holding the value. The flag fires in both cases.
          if (w_at_max) begin
            w_wrap_next = 1'b1;
            w_q_next    = SATURATE ? r_q : (r_q ^ w_up_tgl);
          end else begin
            w_q_next = r_q ^ w_up_tgl;
          end
        end
        MODE_DOWN: begin
          if (w_at_min) begin
            w_wrap_next = 1'b1;
            w_q_next    = SATURATE ? r_q : (r_q ^ w_dn_tgl);
          end else begin
            w_q_next = r_q ^ w_dn_tgl;
          end
        end
        default: begin
          w_q_next = r_q;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q    <= RST_VAL;
      r_wrap <= 1'b0;
    end else begin
      r_q    <= w_q_next;
      r_wrap <= w_wrap_next;
    end
  end

  // q_bar is derived combinationally from the single state register so that
  // it can never diverge from ~q, including while reset is asserted.
  assign o_q     = r_q;
  assign o_q_bar = ~r_q;
  assign o_wrap  = r_wrap;

endmodule

// File: tb/tb_tff_counter.sv
`timescale 1ns/1ps
module tb_tff_counter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic [3:0] t;
  logic       load;
  logic [3:0] load_val;

  logic [3:0] q0, qb0, q1, qb1;
  logic       w0, w1;
  logic [0:0] qn, qbn;
  logic       wn;

  int checks = 0;
  int errors = 0;

  // wrapping instance
  tff_counter #(.WIDTH(4), .RST_VAL(4'h5), .SATURATE(1'b0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_mode(mode), .i_t(t),
    .i_load(load), .i_load_val(load_val),
    .o_q(q0), .o_q_bar(qb0), .o_wrap(w0));

  // saturating instance
  tff_counter #(.WIDTH(4), .RST_VAL(4'h5), .SATURATE(1'b1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_mode(mode), .i_t(t),
    .i_load(load), .i_load_val(load_val),
    .o_q(q1), .o_q_bar(qb1), .o_wrap(w1));

  // single-bit instance
  tff_counter #(.WIDTH(1), .RST_VAL(1'b1), .SATURATE(1'b0)) dutn (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_mode(mode), .i_t(t[0:0]),
    .i_load(load), .i_load_val(load_val[0:0]),
    .o_q(qn), .o_q_bar(qbn), .o_wrap(wn));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (q0 !== 4'h5) begin errors++; $display("FAIL reset_q got=%h exp=5", q0); end
    checks++; if (qb0 !== 4'hA) begin errors++; $display("FAIL reset_qbar got=%h exp=A", qb0); end
    checks++; if (w0 !== 1'b0) begin errors++; $display("FAIL reset_wrap got=%b exp=0", w0); end
    checks++; if (qn !== 1'b1) begin errors++; $display("FAIL reset_w1_q got=%b exp=1", qn); end
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1; mode = 2'b10;
    tick();
    checks++; if (q0 !== 4'h6) begin errors++; $display("FAIL release_first_edge got=%h exp=6", q0); end
    tick();
    checks++; if (q0 !== 4'h7) begin errors++; $display("FAIL count_second_edge got=%h exp=7", q0); end
    // assert reset mid-cycle, well before the next rising edge
    #2 rst_n = 1'b0;
    #1;
    checks++; if (q0 !== 4'h5) begin errors++; $display("FAIL async_reset_q got=%h exp=5", q0); end
    checks++; if (qb0 !== 4'hA) begin errors++; $display("FAIL async_reset_qbar got=%h exp=A", qb0); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (q0 !== 4'h6) begin errors++; $display("FAIL rerelease_edge got=%h exp=6", q0); end
  endtask

  task automatic test_toggle();
    @(negedge clk); load = 1'b1; load_val = 4'h0;
    tick();
    @(negedge clk); load = 1'b0; en = 1'b1; mode = 2'b01; t = 4'b1010;
    tick();
    checks++; if (q0 !== 4'hA) begin errors++; $display("FAIL toggle_1 got=%h exp=A", q0); end
    checks++; if (w0 !== 1'b0) begin errors++; $display("FAIL toggle_1_wrap got=%b exp=0", w0); end
    tick();
    checks++; if (q0 !== 4'h0) begin errors++; $display("FAIL toggle_2 got=%h exp=0", q0); end
    @(negedge clk); t = 4'b0000;
    tick();
    checks++; if (q0 !== 4'h0) begin errors++; $display("FAIL toggle_hold got=%h exp=0", q0); end
    checks++; if (w0 !== 1'b0) begin errors++; $display("FAIL toggle_hold_wrap got=%b exp=0", w0); end
    @(negedge clk); t = 4'b0110;
    tick();
    checks++; if (q0 !== 4'h6) begin errors++; $display("FAIL toggle_3 got=%h exp=6", q0); end
    checks++; if (qb0 !== 4'h9) begin errors++; $display("FAIL toggle_3_qbar got=%h exp=9", qb0); end
    @(negedge clk); mode = 2'b00; t = 4'b1111;
    tick();
    checks++; if (q0 !== 4'h6) begin errors++; $display("FAIL mode_hold got=%h exp=6", q0); end
  endtask

  task automatic test_up_wrap();
    @(negedge clk); load = 1'b1; load_val = 4'hE; t = 4'hF;
    tick();
    @(negedge clk); load = 1'b0; en = 1'b1; mode = 2'b10;
    tick();
    checks++; if (q0 !== 4'hF || w0 !== 1'b0) begin errors++; $display("FAIL up_e1 got=%h/%b exp=F/0", q0, w0); end
    checks++; if (q1 !== 4'hF || w1 !== 1'b0) begin errors++; $display("FAIL upsat_e1 got=%h/%b exp=F/0", q1, w1); end
    tick();
    checks++; if (q0 !== 4'h0 || w0 !== 1'b1) begin errors++; $display("FAIL up_e2 got=%h/%b exp=0/1", q0, w0); end
    checks++; if (q1 !== 4'hF || w1 !== 1'b1) begin errors++; $display("FAIL upsat_e2 got=%h/%b exp=F/1", q1, w1); end
    tick();
    checks++; if (q0 !== 4'h1 || w0 !== 1'b0) begin errors++; $display("FAIL up_e3 got=%h/%b exp=1/0", q0, w0); end
    checks++; if (q1 !== 4'hF || w1 !== 1'b1) begin errors++; $display("FAIL upsat_e3 got=%h/%b exp=F/1", q1, w1); end
    @(negedge clk); load = 1'b1; load_val = 4'h7;
    tick();
    @(negedge clk); load = 1'b0;
    tick();
    checks++; if (q0 !== 4'h8) begin errors++; $display("FAIL up_carry got=%h exp=8", q0); end
  endtask

  task automatic test_down_saturate();
    @(negedge clk); load = 1'b1; load_val = 4'h1;
    tick();
    @(negedge clk); load = 1'b0; en = 1'b1; mode = 2'b11;
    tick();
    checks++; if (q1 !== 4'h0 || w1 !== 1'b0) begin errors++; $display("FAIL dnsat_e1 got=%h/%b exp=0/0", q1, w1); end
    checks++; if (q0 !== 4'h0 || w0 !== 1'b0) begin errors++; $display("FAIL dn_e1 got=%h/%b exp=0/0", q0, w0); end
    tick();
    checks++; if (q1 !== 4'h0 || w1 !== 1'b1) begin errors++; $display("FAIL dnsat_e2 got=%h/%b exp=0/1", q1, w1); end
    checks++; if (q0 !== 4'hF || w0 !== 1'b1) begin errors++; $display("FAIL dn_e2 got=%h/%b exp=F/1", q0, w0); end
    tick();
    checks++; if (q1 !== 4'h0 || w1 !== 1'b1) begin errors++; $display("FAIL dnsat_e3 got=%h/%b exp=0/1", q1, w1); end
    checks++; if (q0 !== 4'hE || w0 !== 1'b0) begin errors++; $display("FAIL dn_e3 got=%h/%b exp=E/0", q0, w0); end
    @(negedge clk); load = 1'b1; load_val = 4'h8;
    tick();
    @(negedge clk); load = 1'b0;
    tick();
    checks++; if (q0 !== 4'h7) begin errors++; $display("FAIL dn_borrow got=%h exp=7", q0); end
  endtask

  task automatic test_priority();
    @(negedge clk); load = 1'b1; load_val = 4'h7; en = 1'b0; mode = 2'b10;
    tick();
    checks++; if (q0 !== 4'h7) begin errors++; $display("FAIL prio_load got=%h exp=7", q0); end
    @(negedge clk); load = 1'b0;
    tick();
    checks++; if (q0 !== 4'h7 || w0 !== 1'b0) begin errors++; $display("FAIL prio_en0_hold got=%h/%b exp=7/0", q0, w0); end
    @(negedge clk); load = 1'b1; load_val = 4'hF; en = 1'b1;
    tick();
    @(negedge clk); load = 1'b0;
    tick();
    checks++; if (w0 !== 1'b1) begin errors++; $display("FAIL prio_wrap_set got=%b exp=1", w0); end
    @(negedge clk); en = 1'b0;
    tick();
    checks++; if (q0 !== 4'h0 || w0 !== 1'b0) begin errors++; $display("FAIL prio_en0_clear got=%h/%b exp=0/0", q0, w0); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); load = 1'b1; load_val = 4'hF; en = 1'b1; mode = 2'b10;
    tick();
    @(negedge clk); load = 1'b0;
    tick();
    checks++; if (q0 !== 4'h0 || w0 !== 1'b1) begin errors++; $display("FAIL b2b_wrap got=%h/%b exp=0/1", q0, w0); end
    @(negedge clk); load = 1'b1; load_val = 4'h3;
    tick();
    checks++; if (q0 !== 4'h3 || w0 !== 1'b0) begin errors++; $display("FAIL b2b_load got=%h/%b exp=3/0", q0, w0); end
    @(negedge clk); load = 1'b0; mode = 2'b11;
    tick();
    checks++; if (q0 !== 4'h2) begin errors++; $display("FAIL b2b_down got=%h exp=2", q0); end
    @(negedge clk); mode = 2'b10;
    tick();
    checks++; if (q0 !== 4'h3) begin errors++; $display("FAIL b2b_up got=%h exp=3", q0); end
    @(negedge clk); mode = 2'b01; t = 4'b1001;
    tick();
    checks++; if (q0 !== 4'hA) begin errors++; $display("FAIL b2b_toggle got=%h exp=A", q0); end
  endtask

  task automatic test_async_reset_during_load();
    @(negedge clk); load = 1'b1; load_val = 4'h9; en = 1'b1; mode = 2'b10;
    tick();
    checks++; if (q0 !== 4'h9) begin errors++; $display("FAIL arl_preload got=%h exp=9", q0); end
    @(negedge clk); load_val = 4'hC;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (q0 !== 4'h5) begin errors++; $display("FAIL arl_assert got=%h exp=5", q0); end
    tick();
    checks++; if (q0 !== 4'h5) begin errors++; $display("FAIL arl_hold1 got=%h exp=5", q0); end
    tick();
    checks++; if (q0 !== 4'h5 || w0 !== 1'b0) begin errors++; $display("FAIL arl_hold2 got=%h/%b exp=5/0", q0, w0); end
    @(negedge clk); rst_n = 1'b1;
    #1;
    checks++; if (q0 !== 4'h5) begin errors++; $display("FAIL arl_release_nowait got=%h exp=5", q0); end
    tick();
    checks++; if (q0 !== 4'hC) begin errors++; $display("FAIL arl_first_edge got=%h exp=C", q0); end
    @(negedge clk); load = 1'b0;
  endtask

  task automatic test_width1();
    @(negedge clk); load = 1'b1; load_val = 4'h1; en = 1'b1;
    tick();
    checks++; if (qn !== 1'b1 || qbn !== 1'b0) begin errors++; $display("FAIL w1_load got=%b/%b exp=1/0", qn, qbn); end
    @(negedge clk); load = 1'b0; mode = 2'b10;
    tick();
    checks++; if (qn !== 1'b0 || wn !== 1'b1) begin errors++; $display("FAIL w1_up_wrap got=%b/%b exp=0/1", qn, wn); end
    @(negedge clk); mode = 2'b11;
    tick();
    checks++; if (qn !== 1'b1 || wn !== 1'b1) begin errors++; $display("FAIL w1_dn_wrap got=%b/%b exp=1/1", qn, wn); end
    tick();
    checks++; if (qn !== 1'b0 || wn !== 1'b0) begin errors++; $display("FAIL w1_dn_plain got=%b/%b exp=0/0", qn, wn); end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 2'b00; t = 4'h0; load = 1'b0; load_val = 4'h0;
    test_reset();
    test_toggle();
    test_up_wrap();
    test_down_saturate();
    test_priority();
    test_back_to_back();
    test_async_reset_during_load();
    test_width1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tff_counter.md
# tff_counter

Parametrised successor to the single-bit T flip-flop: a WIDTH-bit bank of toggle flops with per-bit toggle, up-count, down-count and parallel-load modes. Counting is built as a toggle-flop carry chain: bit i toggles when all lower bits are 1 (up) or 0 (down). Optional saturation and a registered wrap/limit flag are included. It sits wherever the design needs a small event counter, divider or toggle register in place of discrete T flops.

## Interface
- WIDTH, 4, number of toggle flops (≥1)
- RST_VAL, 0, value loaded into q on reset (WIDTH bits)
- SATURATE, 0, 1 = counting stops at the limit instead of wrapping

- clk  in  1  rising-edge clock, sole clock domain
- rst_n  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low
- en  in  1  update enable; 0 = hold (load still honoured)
- mode  in  2  00 hold, 01 per-bit toggle, 10 count up, 11 count down
- t  in  WIDTH  per-bit toggle request, used in mode 01 only
- load  in  1  synchronous parallel load, highest priority after reset
- load_val  in  WIDTH  value written on load
- q  out  WIDTH  register state
- q_bar  out  WIDTH  always ~q, same cycle, never diverges
- wrap  out  1  registered one-cycle pulse: previous edge hit the count limit

## Operation
- Priority per rising edge: rst_n low > load > en=0 (hold) > mode.
- load=1: q <= load_val regardless of en/mode; wrap <= 0.
- mode 00: q holds; wrap <= 0.
- mode 01: q <= q ^ t; bits with t=0 hold; wrap <= 0.
- mode 10 (up): bit i toggles iff q[i-1:0] all ones; bit 0 always toggles. From all-ones:
  - SATURATE=0: q <= 0, wrap <= 1.
  - SATURATE=1: q stays all-ones, wrap <= 1 on every edge spent at the limit.
- mode 11 (down): bit i toggles iff q[i-1:0] all zeros. From 0:
  - SATURATE=0: q <= all-ones, wrap <= 1.
  - SATURATE=1: q stays 0, wrap <= 1.
- Otherwise wrap <= 0. en=0 without load: q holds, wrap <= 0.
- Arithmetic is modulo 2^WIDTH. No internal carry is wider than WIDTH.
- X on t is only observed in mode 01. In other modes t is ignored.

## Timing
- Reset (async assert, any time including mid-count): q=RST_VAL, q_bar=~RST_VAL, wrap=0 immediately, without waiting for a clock edge.
- Reset release is sampled synchronously: the first update occurs on the first rising edge with rst_n high.
- Latency: inputs sampled at edge N; q, q_bar and wrap valid after edge N. wrap lasts exactly one cycle per limit event.
- Mode, en and load may change every cycle; no settling or handshake is required.
- WIDTH=1: modes 10 and 11 both toggle q. wrap asserts on 1→0 (up) or 0→1 (down) when SATURATE=0.

## Test plan
- Reset: rst_n=0 with RST_VAL=4'h5, mid-count -> q=5, q_bar=4'hA, wrap=0 immediately, before any clk edge; release -> first edge updates.
- Toggle: mode=01, q=4'h0, t=4'b1010 for 2 edges -> q=4'hA then 4'h0; t=0 -> hold; wrap stays 0.
- Up wrap: SATURATE=0, load 4'hE, mode=10, 3 edges -> q=F, 0, 1; wrap=1 only in the cycle after F→0.
- Down saturate: SATURATE=1, load 4'h1, mode=11, 3 edges -> q=0, 0, 0; wrap=0, 1, 1.
- Priority: load=1, load_val=4'h7, en=0, mode=10 -> q=7. Then en=0, load=0 -> q holds 7, wrap=0.
- Async reset during load: rst_n falls between edges while load=1 -> q=RST_VAL held until release; load_val never appears on q.
